// File: rtl/uart_rx_fifo_param.sv
// UART receive channel: synchronised, oversampled, majority-voted frame decoder
// feeding a first-word-fall-through FIFO that keeps parity/framing errors per entry.
module uart_rx_fifo_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int RTS_THRESH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 nReset,
  input  logic                                 rx,
  input  logic [DIV_W-1:0]                     divisor,
  input  logic [1:0]                           parity_mode,
  input  logic                                 two_stop,
  input  logic                                 clear,
  input  logic                                 rd_en,
  output logic [DATA_BITS-1:0]                 rd_data,
  output logic                                 rd_perr,
  output logic                                 rd_ferr,
  output logic                                 rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
  output logic                                 full,
  output logic                                 rts,
  output logic                                 busy,
  output logic                                 parity_err,
  output logic                                 frame_err,
  output logic                                 overrun,
  output logic                                 brk
);

  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int EW   = DATA_BITS + 2;
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] PH_S2   = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic xor_red(input logic [DATA_BITS-1:0] v);
    return ^v;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q;
  logic [DIV_W-1:0]       tcnt_q, tcnt_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  state_t                 state_q, state_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic                   pbit_q, pbit_d, perr_q, perr_d, ferr1_q, ferr1_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   perr_flag_q, perr_flag_d, ferr_flag_q, ferr_flag_d;
  logic                   ovr_q, ovr_d, brk_q, brk_d;
  logic                   rx_s, tick_s, decide_s, vote_s;
  logic                   push_s, push_perr_s, push_ferr_s, brk_cond_s;
  logic                   full_s, empty_s, pop_s, wr_s;
  logic [EW-1:0]          head_s;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tick_s   = (tcnt_q >= divisor);
  assign decide_s = tick_s && (phase_q == PH_S2) && (state_q != S_IDLE);
  assign vote_s   = maj3(s0_q, s1_q, rx_s);

  // rx synchroniser shift
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end

  // tick/phase timing, majority sampling and frame FSM
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tcnt_d      = tick_s ? {DIV_W{1'b0}} : tcnt_q + DIV_W'(1);
    bitcnt_d    = bitcnt_q;
    data_d      = data_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    pbit_d      = pbit_q;
    perr_d      = perr_q;
    ferr1_d     = ferr1_q;
    push_s      = 1'b0;
    push_perr_s = perr_q;
    push_ferr_s = 1'b0;
    brk_cond_s  = 1'b0;
    if (clear) begin
      state_d  = S_IDLE;
      phase_d  = {PH_W{1'b0}};
      tcnt_d   = {DIV_W{1'b0}};
      bitcnt_d = {BW{1'b0}};
    end else begin
      if (tick_s && (state_q != S_IDLE)) begin
        if (phase_q == PH_S0) begin
          s0_d = rx_s;
        end else if (phase_q == PH_S1) begin
          s1_d = rx_s;
        end else begin
          s0_d = s0_q;
        end
        phase_d = (phase_q == PH_LAST) ? {PH_W{1'b0}} : phase_q + PH_W'(1);
      end else begin
        phase_d = phase_q;
      end
      case (state_q)
        S_IDLE: begin
          phase_d = {PH_W{1'b0}};
          if (rx_prev_q && !rx_s) begin
            state_d  = S_START;
            tcnt_d   = {DIV_W{1'b0}};
            bitcnt_d = {BW{1'b0}};
            pbit_d   = 1'b0;
            perr_d   = 1'b0;
            ferr1_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (decide_s) begin
            state_d = vote_s ? S_IDLE : S_DATA;
          end else begin
            state_d = S_START;
          end
        end
        S_DATA: begin
          if (decide_s) begin
            data_d = {vote_s, data_q[DATA_BITS-1:1]};
            if (bitcnt_q == BW'(DATA_BITS - 1)) begin
              bitcnt_d = {BW{1'b0}};
              state_d  = ((parity_mode == 2'b01) || (parity_mode == 2'b10)) ? S_PARITY : S_STOP1;
            end else begin
              bitcnt_d = bitcnt_q + BW'(1);
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_PARITY: begin
          if (decide_s) begin
            pbit_d  = vote_s;
            perr_d  = ((xor_red(data_q) ^ vote_s) != (parity_mode == 2'b10));
            state_d = S_STOP1;
          end else begin
            state_d = S_PARITY;
          end
        end
        S_STOP1: begin
          if (decide_s) begin
            ferr1_d = !vote_s;
            if (two_stop) begin
              state_d = S_STOP2;
            end else begin
              push_s      = 1'b1;
              push_ferr_s = !vote_s;
              brk_cond_s  = (data_q == {DATA_BITS{1'b0}}) && !pbit_q && !vote_s;
              state_d     = S_IDLE;
            end
          end else begin
            state_d = S_STOP1;
          end
        end
        S_STOP2: begin
          if (decide_s) begin
            push_s      = 1'b1;
            push_ferr_s = ferr1_q || !vote_s;
            brk_cond_s  = (data_q == {DATA_BITS{1'b0}}) && !pbit_q && ferr1_q;
            state_d     = S_IDLE;
          end else begin
            state_d = S_STOP2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping and sticky status; a full FIFO accepts a push only alongside a pop
  always_comb begin
    full_s      = (count_q == CW'(FIFO_DEPTH));
    empty_s     = (count_q == {CW{1'b0}});
    pop_s       = rd_en && !empty_s && !clear;
    wr_s        = push_s && !clear && (!full_s || pop_s);
    wr_ptr_d    = wr_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    perr_flag_d = perr_flag_q || (push_s && push_perr_s);
    ferr_flag_d = ferr_flag_q || (push_s && push_ferr_s);
    ovr_d       = ovr_q || (push_s && full_s && !pop_s);
    brk_d       = push_s && brk_cond_s;
    if (clear) begin
      wr_ptr_d    = {PW{1'b0}};
      rd_ptr_d    = {PW{1'b0}};
      count_d     = {CW{1'b0}};
      perr_flag_d = 1'b0;
      ferr_flag_d = 1'b0;
      ovr_d       = 1'b0;
      brk_d       = 1'b0;
    end else if (wr_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !wr_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_q      <= {SYNC_STAGES{1'b1}};
      rx_prev_q   <= 1'b1;
      tcnt_q      <= {DIV_W{1'b0}};
      phase_q     <= {PH_W{1'b0}};
      state_q     <= S_IDLE;
      bitcnt_q    <= {BW{1'b0}};
      data_q      <= {DATA_BITS{1'b0}};
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      pbit_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr1_q     <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      perr_flag_q <= 1'b0;
      ferr_flag_q <= 1'b0;
      ovr_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_s;
      tcnt_q      <= tcnt_d;
      phase_q     <= phase_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      data_q      <= data_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      pbit_q      <= pbit_d;
      perr_q      <= perr_d;
      ferr1_q     <= ferr1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      perr_flag_q <= perr_flag_d;
      ferr_flag_q <= ferr_flag_d;
      ovr_q       <= ovr_d;
      brk_q       <= brk_d;
    end
  end

  // entry storage, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= {push_ferr_s, push_perr_s, data_q};
    end
  end

  assign head_s     = empty_s ? {EW{1'b0}} : mem_q[rd_ptr_q];
  assign rd_data    = head_s[DATA_BITS-1:0];
  assign rd_perr    = head_s[DATA_BITS];
  assign rd_ferr    = head_s[DATA_BITS+1];
  assign rd_valid   = !empty_s;
  assign count      = count_q;
  assign full       = full_s;
  assign rts        = (count_q >= CW'(RTS_THRESH));
  assign busy       = (state_q != S_IDLE);
  assign parity_err = perr_flag_q;
  assign frame_err  = ferr_flag_q;
  assign overrun    = ovr_q;
  assign brk        = brk_q;

endmodule
